// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM command/address bus, runs the auto-refresh timer
// and grants the bus to the init, refresh, write and read engines.
module sdram_arbiter #(
    parameter int          REF_PERIOD = 780,
    parameter int          CNT_W      = 10,
    parameter logic [4:0]  CMD_NOP    = 5'b10111
) (
    input  logic        S_CLK,
    input  logic        RST,
    input  logic        init_done,
    input  logic [4:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        aref_ack,
    input  logic [4:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    input  logic        write_req,
    input  logic        write_ack,
    input  logic [4:0]  write_cmd,
    input  logic [11:0] write_addr,
    input  logic        read_req,
    input  logic        read_ack,
    input  logic [4:0]  read_cmd,
    input  logic [11:0] read_addr,
    output logic        aref_en,
    output logic        write_en,
    output logic        read_en,
    output logic [4:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic        ref_miss
);
    typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic aref_pending, last_wr, wrap;
    logic [4:0] cmd_mux;
    logic [11:0] addr_mux;
    assign wrap = (state != INIT) && (cnt == CNT_W'(REF_PERIOD - 1));
    always_comb begin
        state_n  = state;
        cmd_mux  = CMD_NOP;
        addr_mux = 12'h400;
        case (state)
            INIT: begin
                cmd_mux  = init_cmd;
                addr_mux = init_addr;
                state_n  = init_done ? IDLE : INIT;
            end
            // pending refresh beats user traffic; simultaneous requests alternate
            IDLE: state_n = aref_pending ? AREF :
                            (write_req && read_req) ? (last_wr ? READ : WRITE) :
                            write_req ? WRITE : read_req ? READ : IDLE;
            AREF: begin
                cmd_mux  = aref_cmd;
                addr_mux = aref_addr;
                state_n  = aref_ack ? IDLE : AREF;
            end
            WRITE: begin
                cmd_mux  = write_cmd;
                addr_mux = write_addr;
                state_n  = write_ack ? IDLE : WRITE;
            end
            READ: begin
                cmd_mux  = read_cmd;
                addr_mux = read_addr;
                state_n  = read_ack ? IDLE : READ;
            end
            default: state_n = INIT;
        endcase
    end
    // reset forces a NOP onto the pins without waiting for a clock
    assign sdram_cmd  = RST ? CMD_NOP : cmd_mux;
    assign sdram_addr = RST ? 12'h000 : addr_mux;
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            state        <= INIT;
            cnt          <= '0;
            aref_pending <= 1'b0;
            last_wr      <= 1'b0;
            ref_miss     <= 1'b0;
            aref_en      <= 1'b0;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
        end else begin
            state    <= state_n;
            aref_en  <= state_n == AREF;
            write_en <= state_n == WRITE;
            read_en  <= state_n == READ;
            cnt      <= (state == INIT || wrap) ? '0 : cnt + 1'b1;
            if (wrap)
                aref_pending <= 1'b1;
            else if (state == IDLE && state_n == AREF)
                aref_pending <= 1'b0;
            if (wrap && aref_pending)
                ref_miss <= 1'b1;
            if (state == IDLE && state_n == WRITE)
                last_wr <= 1'b1;
            else if (state == IDLE && state_n == READ)
                last_wr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: random and directed traffic against a cycle-level model of
// the arbitration rules; every cycle compares grants, bus mux and ref_miss.
module tb_sdram_arbiter;
    localparam int RP = 780;
    localparam logic [4:0] NOP = 5'b10111;
    logic S_CLK = 1'b0, RST = 1'b1, init_done = 1'b0;
    logic [4:0] init_cmd = '0, aref_cmd = '0, write_cmd = '0, read_cmd = '0;
    logic [11:0] init_addr = '0, aref_addr = '0, write_addr = '0, read_addr = '0;
    logic aref_ack = 1'b0, write_req = 1'b0, write_ack = 1'b0, read_req = 1'b0, read_ack = 1'b0;
    logic aref_en, write_en, read_en, ref_miss;
    logic [4:0] sdram_cmd;
    logic [11:0] sdram_addr;
    int errors = 0, checks = 0;
    // model: m_g is the granted engine (0 none, 1 refresh, 2 write, 3 read)
    int m_g = 0, m_tmr = 0, m_gcyc = 0;
    bit m_init = 1, m_pend = 0, m_miss = 0, m_lw = 0;
    int lat_a = 3, lat_w = 8, lat_r = 8, wr_mode = 0, rd_mode = 0;
    bit spur = 0, init_rand = 0, rnd_lat = 0;
    int prev_dut = 0;
    int gq[$];

    sdram_arbiter dut (
        .S_CLK(S_CLK), .RST(RST), .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_ack(aref_ack), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .write_req(write_req), .write_ack(write_ack), .write_cmd(write_cmd), .write_addr(write_addr),
        .read_req(read_req), .read_ack(read_ack), .read_cmd(read_cmd), .read_addr(read_addr),
        .aref_en(aref_en), .write_en(write_en), .read_en(read_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .ref_miss(ref_miss)
    );

    always #5 S_CLK = ~S_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        logic [4:0] ec;
        logic [11:0] ea;
        if (RST) begin ec = NOP; ea = 12'h000; end
        else if (m_init) begin ec = init_cmd; ea = init_addr; end
        else if (m_g == 1) begin ec = aref_cmd; ea = aref_addr; end
        else if (m_g == 2) begin ec = write_cmd; ea = write_addr; end
        else if (m_g == 3) begin ec = read_cmd; ea = read_addr; end
        else begin ec = NOP; ea = 12'h400; end
        chk("aref_en", aref_en, !RST && m_g == 1);
        chk("write_en", write_en, !RST && m_g == 2);
        chk("read_en", read_en, !RST && m_g == 3);
        chk("sdram_cmd", sdram_cmd, ec);
        chk("sdram_addr", sdram_addr, ea);
        chk("ref_miss", ref_miss, !RST && m_miss);
    endtask

    task automatic step_model();
        bit wrap;
        int g;
        if (RST) begin
            m_init = 1; m_g = 0; m_tmr = 0; m_pend = 0; m_miss = 0; m_lw = 0; m_gcyc = 0;
            return;
        end
        wrap = !m_init && m_tmr == RP - 1;
        m_tmr = m_init ? 0 : (m_tmr + 1) % RP;
        g = m_g;
        if (m_init) m_init = !init_done;
        else if (m_g == 0) g = m_pend ? 1 : (write_req && read_req) ? (m_lw ? 3 : 2) :
                               write_req ? 2 : read_req ? 3 : 0;
        else if ((m_g == 1 && aref_ack) || (m_g == 2 && write_ack) || (m_g == 3 && read_ack)) g = 0;
        if (m_g == 0 && g == 2) m_lw = 1;
        if (m_g == 0 && g == 3) m_lw = 0;
        if (wrap) begin
            if (m_pend) m_miss = 1;
            m_pend = 1;
        end else if (m_g == 0 && g == 1) m_pend = 0;
        m_gcyc = (g == m_g && g != 0) ? m_gcyc + 1 : 0;
        m_g = g;
    endtask

    task automatic drive();
        {init_cmd, aref_cmd, write_cmd, read_cmd} = 20'($urandom);
        {init_addr, aref_addr} = 24'($urandom);
        {write_addr, read_addr} = 24'($urandom);
        if (init_rand) init_done = 1'($urandom);
        if (rnd_lat && m_g == 0) begin
            lat_a = $urandom_range(0, 4);
            lat_w = $urandom_range(0, 10);
            lat_r = $urandom_range(0, 10);
        end
        write_req = wr_mode == 2 ? 1'($urandom) : wr_mode == 1;
        read_req  = rd_mode == 2 ? 1'($urandom) : rd_mode == 1;
        aref_ack  = m_g == 1 ? m_gcyc == lat_a : spur && 1'($urandom);
        write_ack = m_g == 2 ? m_gcyc == lat_w : spur && 1'($urandom);
        read_ack  = m_g == 3 ? m_gcyc == lat_r : spur && 1'($urandom);
    endtask

    task automatic tick();
        int cur;
        @(negedge S_CLK);
        cmp_all();
        cur = aref_en ? 1 : write_en ? 2 : read_en ? 3 : 0;
        if (cur != 0 && prev_dut == 0) gq.push_back(cur);
        prev_dut = cur;
        @(posedge S_CLK);
        step_model();
        #1 drive();
    endtask

    task automatic drain();
        int n = 0;
        wr_mode = 0;
        rd_mode = 0;
        while (m_g != 0 && n < 3000) begin tick(); n++; end
        chk("drain_bound", n < 3000, 1);
        repeat (2) tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        RST = 1'b0;
        repeat (20) tick();
        init_done = 1'b1;
        repeat (3) tick();
        init_rand = 1;
        wr_mode = 1; lat_w = 8;
        repeat (60) tick();
        drain();
        gq.delete();
        wr_mode = 1; rd_mode = 1; lat_w = 6; lat_r = 6;
        repeat (60) tick();
        chk("alt_first_read", gq[0], 3);
        for (int i = 0; i < 3; i++) chk("alt_order", gq[i] != gq[i+1], 1);
        drain();
        n = 0;
        while (m_tmr != RP - 30 && n < 2000) begin tick(); n++; end
        chk("tmr_bound", n < 2000, 1);
        gq.delete();
        wr_mode = 1; lat_w = 40;
        n = 0;
        while (m_g != 2 && n < 50) begin tick(); n++; end
        chk("wr_grant_bound", n < 50, 1);
        rd_mode = 1;
        repeat (80) tick();
        chk("wrap_wr", gq[0], 2);
        chk("wrap_aref", gq[1], 1);
        chk("wrap_rd", gq[2], 3);
        drain();
        wr_mode = 1; lat_w = 2 * RP + 50;
        repeat (2 * RP + 80) tick();
        chk("ref_miss_set", ref_miss, 1);
        drain();
        lat_w = 5;
        spur = 1; rnd_lat = 1; wr_mode = 2; rd_mode = 2;
        repeat (3000) tick();
        chk("ref_miss_sticky", ref_miss, 1);
        drain();
        spur = 0; rnd_lat = 0; lat_r = 100; rd_mode = 1;
        n = 0;
        while (m_g != 3 && n < 50) begin tick(); n++; end
        chk("rd_grant_bound", n < 50, 1);
        repeat (3) tick();
        #2 RST = 1'b1;
        #1;
        chk("rst_read_en", read_en, 0);
        chk("rst_cmd", sdram_cmd, NOP);
        chk("rst_addr", sdram_addr, 0);
        tick();
        RST = 1'b0; init_rand = 0; init_done = 1'b0; rd_mode = 0;
        repeat (5) tick();
        @(negedge S_CLK);
        chk("post_rst_init_cmd", sdram_cmd, init_cmd);
        chk("post_rst_read_en", read_en, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
